// File: rtl/uart_mem_bridge.sv
// uart_mem_bridge: turns UART command frames into memory debug-port
// requests and streams 42-bit read responses back out as six bytes.
//
// Ports:
//   clk, reset        system clock, async active-high reset
//   rx_byte/rx_valid  incoming UART bytes (one-cycle strobe)
//   tx_byte/tx_valid/tx_ready  outgoing bytes, valid/ready handshake
//   enable            CPU running; memory port used only while low
//   write_mem_req, rw_flag, target_mem_type, target_addr,
//   uart_rx_data_in   memory debug command
//   uart_tx_data_out, mem_tx_data_ready  memory read response
//   busy, err         not-idle flag, sticky error flag
//
// Option: define UART_BRIDGE_WRITE_ACK_EN to answer every write
// with a single 0xA5 byte.

module uart_mem_bridge #(
    parameter int FRAME_TIMEOUT = 100000,
    parameter int RESP_TIMEOUT  = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_byte,
    input  logic        rx_valid,
    output logic [7:0]  tx_byte,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic        enable,
    output logic        write_mem_req,
    output logic        rw_flag,
    output logic        target_mem_type,
    output logic [8:0]  target_addr,
    output logic [31:0] uart_rx_data_in,
    input  logic [41:0] uart_tx_data_out,
    input  logic        mem_tx_data_ready,
    output logic        busy,
    output logic        err
);

    localparam int FTW = $clog2(FRAME_TIMEOUT + 1);
    localparam int RTW = $clog2(RESP_TIMEOUT + 1);
    localparam logic [FTW-1:0] FT_LAST = FTW'(FRAME_TIMEOUT - 1);
    localparam logic [RTW-1:0] RT_LAST = RTW'(RESP_TIMEOUT - 1);

`ifdef UART_BRIDGE_WRITE_ACK_EN
    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_DATA, S_PEND, S_WAIT, S_TX, S_ACK
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_DATA, S_PEND, S_WAIT, S_TX
    } state_t;
`endif

    state_t state_q, state_d;

    // frame assembly registers
    logic           rw_q;
    logic           type_q;
    logic [8:0]     addr_q;
    logic [31:0]    data_q;
    logic [1:0]     byte_cnt_q;

    // command registers seen by the memories
    logic           out_rw_q;
    logic           out_type_q;
    logic [8:0]     out_addr_q;
    logic [31:0]    out_data_q;

    logic [41:0]    resp_q;
    logic [2:0]     tx_cnt_q;
    logic [FTW-1:0] ftimer_q;
    logic [RTW-1:0] rtimer_q;
    logic           err_q;

    // FSM strobes
    logic hdr_ld, addr_ld, data_ld, pend_ld, resp_ld;
    logic tx_adv, err_set, req, txv;

    logic [8:0]  addr_nxt;
    logic [31:0] data_nxt;

    assign addr_nxt = addr_ld ? {addr_q[8], rx_byte} : addr_q;
    assign data_nxt = data_ld ? {data_q[23:0], rx_byte} : data_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        hdr_ld  = 1'b0;
        addr_ld = 1'b0;
        data_ld = 1'b0;
        pend_ld = 1'b0;
        resp_ld = 1'b0;
        tx_adv  = 1'b0;
        err_set = 1'b0;
        req     = 1'b0;
        txv     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (rx_valid) begin
                    hdr_ld  = 1'b1;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (rx_valid) begin
                    addr_ld = 1'b1;
                    if (rw_q) begin
                        state_d = S_DATA;
                    end else begin
                        pend_ld = 1'b1;
                        state_d = S_PEND;
                    end
                end else if (ftimer_q == FT_LAST) begin
                    err_set = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_DATA: begin
                if (rx_valid) begin
                    data_ld = 1'b1;
                    if (byte_cnt_q == 2'd3) begin
                        pend_ld = 1'b1;
                        state_d = S_PEND;
                    end
                end else if (ftimer_q == FT_LAST) begin
                    err_set = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_PEND: begin
                err_set = rx_valid;
                // the CPU owns the memories while enable is high
                if (!enable) begin
                    req = 1'b1;
                    if (out_rw_q) begin
`ifdef UART_BRIDGE_WRITE_ACK_EN
                        state_d = S_ACK;
`else
                        state_d = S_IDLE;
`endif
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                err_set = rx_valid;
                if (mem_tx_data_ready) begin
                    resp_ld = 1'b1;
                    state_d = S_TX;
                end else if (rtimer_q == RT_LAST) begin
                    err_set = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_TX: begin
                err_set = rx_valid;
                txv     = 1'b1;
                if (tx_ready) begin
                    tx_adv = 1'b1;
                    if (tx_cnt_q == 3'd5) state_d = S_IDLE;
                end
            end
`ifdef UART_BRIDGE_WRITE_ACK_EN
            S_ACK: begin
                err_set = rx_valid;
                txv     = 1'b1;
                if (tx_ready) state_d = S_IDLE;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rw_q       <= 1'b0;
            type_q     <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            byte_cnt_q <= '0;
            out_rw_q   <= 1'b0;
            out_type_q <= 1'b0;
            out_addr_q <= '0;
            out_data_q <= '0;
            resp_q     <= '0;
            tx_cnt_q   <= '0;
            ftimer_q   <= '0;
            rtimer_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            if (hdr_ld) begin
                rw_q      <= rx_byte[7];
                type_q    <= rx_byte[6];
                addr_q[8] <= rx_byte[0];
            end
            if (addr_ld) addr_q[7:0] <= rx_byte;
            if (data_ld) data_q <= data_nxt;

            if (addr_ld)      byte_cnt_q <= '0;
            else if (data_ld) byte_cnt_q <= byte_cnt_q + 2'd1;

            // last frame byte is folded in directly so the command
            // is complete on the PEND entry edge
            if (pend_ld) begin
                out_rw_q   <= rw_q;
                out_type_q <= type_q;
                out_addr_q <= addr_nxt;
                out_data_q <= data_nxt;
            end

            if (resp_ld) resp_q <= uart_tx_data_out;

            if (state_q != S_TX) tx_cnt_q <= '0;
            else if (tx_adv)     tx_cnt_q <= tx_cnt_q + 3'd1;

            if ((state_q == S_ADDR || state_q == S_DATA) && !rx_valid)
                ftimer_q <= ftimer_q + FTW'(1);
            else
                ftimer_q <= '0;

            if (state_q == S_WAIT) rtimer_q <= rtimer_q + RTW'(1);
            else                   rtimer_q <= '0;

            err_q <= err_q | err_set;
        end
    end

    always_comb begin
        tx_byte = 8'h00;
        if (state_q == S_TX) begin
            case (tx_cnt_q)
                3'd0:    tx_byte = {6'b0, resp_q[41:40]};
                3'd1:    tx_byte = resp_q[39:32];
                3'd2:    tx_byte = resp_q[31:24];
                3'd3:    tx_byte = resp_q[23:16];
                3'd4:    tx_byte = resp_q[15:8];
                3'd5:    tx_byte = resp_q[7:0];
                default: tx_byte = 8'h00;
            endcase
        end
`ifdef UART_BRIDGE_WRITE_ACK_EN
        else if (state_q == S_ACK) begin
            tx_byte = 8'hA5;
        end
`endif
    end

    assign tx_valid        = txv;
    assign write_mem_req   = req;
    assign rw_flag         = out_rw_q;
    assign target_mem_type = out_type_q;
    assign target_addr     = out_addr_q;
    assign uart_rx_data_in = out_data_q;
    assign busy            = (state_q != S_IDLE);
    assign err             = err_q;

endmodule

// File: tb/tb_uart_mem_bridge.sv
// tb_uart_mem_bridge: randomized command frames against a queue-based
// model of expected memory commands and response bytes.
`timescale 1ns/1ps

module tb_uart_mem_bridge;

    localparam int FT = 64;
    localparam int RT = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_byte = '0;
    logic        rx_valid = 1'b0;
    logic [7:0]  tx_byte;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic        enable = 1'b0;
    logic        write_mem_req;
    logic        rw_flag;
    logic        target_mem_type;
    logic [8:0]  target_addr;
    logic [31:0] uart_rx_data_in;
    logic [41:0] uart_tx_data_out = '0;
    logic        mem_tx_data_ready = 1'b0;
    logic        busy;
    logic        err;

    uart_mem_bridge #(.FRAME_TIMEOUT(FT), .RESP_TIMEOUT(RT)) dut (
        .clk(clk), .reset(reset),
        .rx_byte(rx_byte), .rx_valid(rx_valid),
        .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .enable(enable), .write_mem_req(write_mem_req),
        .rw_flag(rw_flag), .target_mem_type(target_mem_type),
        .target_addr(target_addr), .uart_rx_data_in(uart_rx_data_in),
        .uart_tx_data_out(uart_tx_data_out),
        .mem_tx_data_ready(mem_tx_data_ready),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rw;
        logic        ty;
        logic [8:0]  a;
        logic [31:0] d;
    } cmd_t;

    cmd_t       exp_cmd[$];
    logic [7:0] exp_tx[$];
    bit [31:0]  ref_d[512];
    bit [31:0]  ref_i[512];
    bit [31:0]  dm[512];
    bit [31:0]  im[512];

    int total = 0;
    int bad = 0;
    int req_cnt = 0;
    int tx_seen = 0;
    int rsp_lat = 1;
    int stall_at = -1;
    int stall_cyc = 0;
    bit prev_req = 0;
    bit prev_stall = 0;
    logic [7:0]  prev_byte = '0;
    cmd_t        mon_c;
    logic [41:0] rsp;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // command monitor
    always @(negedge clk) begin
        if (reset) begin
            prev_req = 0;
        end else begin
            if (write_mem_req) begin
                req_cnt++;
                chk("req_en", 64'(enable), 64'(0));
                chk("req_pulse", 64'(prev_req), 64'(0));
                if (exp_cmd.size() == 0) begin
                    chk("req_extra", 64'(1), 64'(0));
                end else begin
                    mon_c = exp_cmd.pop_front();
                    chk("req_rw", 64'(rw_flag), 64'(mon_c.rw));
                    chk("req_type", 64'(target_mem_type), 64'(mon_c.ty));
                    chk("req_addr", 64'(target_addr), 64'(mon_c.a));
                    if (mon_c.rw)
                        chk("req_data", 64'(uart_rx_data_in), 64'(mon_c.d));
                end
            end
            prev_req = write_mem_req;
        end
    end

    // transmit monitor
    always @(negedge clk) begin
        if (reset) begin
            prev_stall = 0;
        end else begin
            if (prev_stall)
                chk("tx_hold", 64'({tx_valid, tx_byte}),
                    64'({1'b1, prev_byte}));
            if (tx_valid && tx_ready) begin
                tx_seen++;
                if (exp_tx.size() == 0)
                    chk("tx_extra", 64'(1), 64'(0));
                else
                    chk("tx_byte", 64'(tx_byte), 64'(exp_tx.pop_front()));
            end
            prev_stall = tx_valid && !tx_ready;
            prev_byte  = tx_byte;
        end
    end

    // memory model behind the debug port
    always begin
        @(negedge clk);
        if (!reset && write_mem_req) begin
            if (rw_flag) begin
                if (target_mem_type) im[target_addr] = uart_rx_data_in;
                else                 dm[target_addr] = uart_rx_data_in;
            end else if (rsp_lat != 0) begin
                rsp = {target_mem_type, target_addr,
                       target_mem_type ? im[target_addr] : dm[target_addr]};
                repeat (rsp_lat) @(posedge clk);
                #1;
                uart_tx_data_out  = rsp;
                mem_tx_data_ready = 1'b1;
                @(posedge clk);
                #1;
                mem_tx_data_ready = 1'b0;
                uart_tx_data_out  = 42'($urandom);
            end
        end
    end

    // transmitter back-pressure
    always begin
        @(posedge clk);
        #1;
        if (stall_at >= 0 && tx_seen == stall_at) begin
            stall_at  = -1;
            stall_cyc = 3;
        end
        if (stall_cyc > 0) begin
            tx_ready = 1'b0;
            stall_cyc--;
        end else begin
            tx_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic send_byte(input logic [7:0] b);
        rx_byte  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output int n);
        n = 0;
        while (busy && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("idle_to", 64'(busy), 64'(0));
    endtask

    task automatic do_cmd(input bit rw, input bit ty, input bit [8:0] a,
                          input bit [31:0] d, input int lat,
                          input int hold, input bit wt);
        logic [7:0] b[6];
        bit [31:0]  m;
        int         n;
        rsp_lat = lat;
        exp_cmd.push_back({rw, ty, a, d});
        if (rw) begin
            if (ty) ref_i[a] = d;
            else    ref_d[a] = d;
`ifdef UART_BRIDGE_WRITE_ACK_EN
            exp_tx.push_back(8'hA5);
`endif
        end else if (lat != 0) begin
            m = ty ? ref_i[a] : ref_d[a];
            exp_tx.push_back({6'b0, ty, a[8]});
            exp_tx.push_back(a[7:0]);
            exp_tx.push_back(m[31:24]);
            exp_tx.push_back(m[23:16]);
            exp_tx.push_back(m[15:8]);
            exp_tx.push_back(m[7:0]);
        end
        b[0] = {rw, ty, 5'($urandom), a[8]};
        b[1] = a[7:0];
        b[2] = d[31:24];
        b[3] = d[23:16];
        b[4] = d[15:8];
        b[5] = d[7:0];
        enable = (hold > 0);
        for (int k = 0; k < (rw ? 6 : 2); k++) begin
            send_byte(b[k]);
            if (k < (rw ? 5 : 1))
                repeat ($urandom_range(0, 3)) begin
                    @(posedge clk);
                    #1;
                end
        end
        if (hold > 0) begin
            repeat (hold) begin
                @(posedge clk);
                #1;
            end
            enable = 1'b0;
        end
        if (wt) begin
            wait_idle(300, n);
            chk("cmdq_left", 64'(exp_cmd.size()), 64'(0));
            chk("txq_left", 64'(exp_tx.size()), 64'(0));
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_cmd.delete();
        exp_tx.delete();
    endtask

    bit        r_rw, r_ty;
    bit [8:0]  r_a;
    bit [31:0] r_d;
    int        r_hold, n, base;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_txv", 64'(tx_valid), 64'(0));
        chk("rst_txb", 64'(tx_byte), 64'(0));
        chk("rst_req", 64'(write_mem_req), 64'(0));
        chk("rst_rw", 64'(rw_flag), 64'(0));
        chk("rst_addr", 64'({target_mem_type, target_addr}), 64'(0));
        chk("rst_data", 64'(uart_rx_data_in), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_err", 64'(err), 64'(0));
        reset = 1'b0;
        @(posedge clk);
        #1;

        do_cmd(1, 0, 9'h005, 32'hDEADBEEF, 1, 0, 1);
        chk("w_dm5", 64'(dm[5]), 64'(32'hDEADBEEF));
        do_cmd(1, 0, 9'h1FF, 32'h12345678, 1, 0, 1);
        stall_at = tx_seen + 2;
        do_cmd(0, 0, 9'h1FF, 32'h0, 1, 0, 1);

        for (int i = 0; i < 40; i++) begin
            r_rw   = 1'($urandom_range(0, 1));
            r_ty   = 1'($urandom_range(0, 1));
            r_a    = {1'($urandom_range(0, 1)), 5'b0,
                      3'($urandom_range(0, 7))};
            r_d    = $urandom;
            r_hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 6) : 0;
            do_cmd(r_rw, r_ty, r_a, r_d, $urandom_range(1, 4), r_hold, 1);
        end
        chk("rand_err", 64'(err), 64'(0));

        // held off by enable, plus a stray byte while pending
        base = req_cnt;
        exp_cmd.push_back({1'b1, 1'b1, 9'h0AA, 32'hCAFEF00D});
        enable = 1'b1;
        send_byte(8'hC0);
        send_byte(8'hAA);
        send_byte(8'hCA);
        send_byte(8'hFE);
        send_byte(8'hF0);
        send_byte(8'h0D);
        repeat (50) begin
            @(posedge clk);
            #1;
        end
        chk("en_noreq", 64'(req_cnt), 64'(base));
        chk("en_busy", 64'(busy), 64'(1));
        chk("en_err0", 64'(err), 64'(0));
        send_byte(8'h55);
        chk("drop_err", 64'(err), 64'(1));
        enable = 1'b0;
        wait_idle(20, n);
        chk("en_onereq", 64'(req_cnt), 64'(base + 1));
        chk("en_im", 64'(im[9'h0AA]), 64'(32'hCAFEF00D));
        pulse_reset();
        chk("clr_err", 64'(err), 64'(0));

        // frame timeout
        base = req_cnt;
        send_byte(8'h80);
        send_byte(8'h10);
        chk("fto_err0", 64'(err), 64'(0));
        wait_idle(FT + 20, n);
        chk("fto_cyc", 64'(n), 64'(FT));
        chk("fto_err", 64'(err), 64'(1));
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        chk("fto_noreq", 64'(req_cnt), 64'(base));
        ref_d[9'h010] = 32'h0;
        dm[9'h010]    = 32'h0;
        do_cmd(0, 0, 9'h010, 32'h0, 2, 0, 1);
        pulse_reset();

        // response timeout
        base = tx_seen;
        do_cmd(0, 1, 9'h003, 32'h0, 0, 0, 0);
        wait_idle(RT + 20, n);
        chk("rto_cyc", 64'(n), 64'(RT + 1));
        chk("rto_err", 64'(err), 64'(1));
        chk("rto_notx", 64'(tx_seen), 64'(base));
        chk("rto_cmdq", 64'(exp_cmd.size()), 64'(0));

        // reset while byte3 of a response is on the wire
        pulse_reset();
        base = tx_seen;
        do_cmd(0, 0, 9'h005, 32'h0, 1, 0, 0);
        n = 0;
        while (tx_seen < base + 3 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("tx3_seen", 64'(tx_seen), 64'(base + 3));
        chk("tx3_valid", 64'(tx_valid), 64'(1));
        reset = 1'b1;
        #1;
        chk("mid_txv", 64'(tx_valid), 64'(0));
        chk("mid_txb", 64'(tx_byte), 64'(0));
        chk("mid_busy", 64'(busy), 64'(0));
        chk("mid_out", 64'({rw_flag, target_mem_type, target_addr,
                            uart_rx_data_in, write_mem_req}), 64'(0));
        exp_tx.delete();
        exp_cmd.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("post_busy", 64'(busy), 64'(0));
        chk("post_err", 64'(err), 64'(0));
        do_cmd(0, 0, 9'h005, 32'h0, 1, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
